// File: rtl/nv_nvdla_sdp_hls_relu_bwd.sv
// ReLU backward gate: records x>0 per forward element in a mask FIFO and applies
// those bits in order to the returning gradient stream through a registered output.
module nv_nvdla_sdp_hls_relu_bwd #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_AW    = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  op_en,
  input  logic                  mask_flush,
  input  logic                  fwd_pvld,
  output logic                  fwd_prdy,
  input  logic [DATA_WIDTH-1:0] fwd_pd,
  input  logic                  grad_in_pvld,
  output logic                  grad_in_prdy,
  input  logic [DATA_WIDTH-1:0] grad_in_pd,
  output logic                  grad_out_pvld,
  input  logic                  grad_out_prdy,
  output logic [DATA_WIDTH-1:0] grad_out_pd,
  output logic [MASK_AW:0]      mask_cnt,
  output logic [31:0]           zero_cnt
);

  localparam int DEPTH = 1 << MASK_AW;
  localparam logic [MASK_AW:0] CNT_FULL = (MASK_AW+1)'(DEPTH);

  logic [DEPTH-1:0]      mask_mem_q, mask_mem_d;
  logic [MASK_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [MASK_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [MASK_AW:0]      mask_cnt_q, mask_cnt_d;
  logic [31:0]           zero_cnt_q, zero_cnt_d;
  logic                  out_pvld_q, out_pvld_d;
  logic [DATA_WIDTH-1:0] out_pd_q, out_pd_d;

  logic fwd_mask;
  logic m_head;
  logic push;
  logic pop;

  assign fwd_mask = ~fwd_pd[DATA_WIDTH-1] & (|fwd_pd);
  assign m_head   = mask_mem_q[rd_ptr_q];

  // Ready depends only on registered occupancy, so a mask never falls through an empty FIFO.
  assign fwd_prdy     = op_en & ~mask_flush & (mask_cnt_q != CNT_FULL);
  assign grad_in_prdy = op_en & ~mask_flush & (mask_cnt_q != '0) &
                        (~out_pvld_q | grad_out_prdy);

  assign push = fwd_pvld & fwd_prdy;
  assign pop  = grad_in_pvld & grad_in_prdy;

  always_comb begin
    mask_mem_d = mask_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mask_cnt_d = mask_cnt_q;
    zero_cnt_d = zero_cnt_q;
    out_pvld_d = out_pvld_q;
    out_pd_d   = out_pd_q;

    if (mask_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mask_cnt_d = '0;
      zero_cnt_d = '0;
    end else begin
      if (push) begin
        mask_mem_d[wr_ptr_q] = fwd_mask;
        wr_ptr_d             = wr_ptr_q + MASK_AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + MASK_AW'(1);
      end
      if (push && !pop) begin
        mask_cnt_d = mask_cnt_q + (MASK_AW+1)'(1);
      end else if (pop && !push) begin
        mask_cnt_d = mask_cnt_q - (MASK_AW+1)'(1);
      end
      if (pop && !m_head && (zero_cnt_q != 32'hFFFF_FFFF)) begin
        zero_cnt_d = zero_cnt_q + 32'd1;
      end
    end

    // The output register drains independently of flush.
    if (pop) begin
      out_pvld_d = 1'b1;
      out_pd_d   = m_head ? grad_in_pd : '0;
    end else if (grad_out_prdy) begin
      out_pvld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mask_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mask_cnt_q <= '0;
      zero_cnt_q <= '0;
      out_pvld_q <= 1'b0;
      out_pd_q   <= '0;
    end else begin
      mask_mem_q <= mask_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mask_cnt_q <= mask_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      out_pvld_q <= out_pvld_d;
      out_pd_q   <= out_pd_d;
    end
  end

  assign grad_out_pvld = out_pvld_q;
  assign grad_out_pd   = out_pd_q;
  assign mask_cnt      = mask_cnt_q;
  assign zero_cnt      = zero_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_relu_bwd.sv
// Bench for the ReLU backward gate: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_nv_nvdla_sdp_hls_relu_bwd;

  logic        clk;
  logic        rst_n;
  logic        op_en;
  logic        mask_flush;
  logic        fwd_pvld;
  logic        fwd_prdy;
  logic [31:0] fwd_pd;
  logic        grad_in_pvld;
  logic        grad_in_prdy;
  logic [31:0] grad_in_pd;
  logic        grad_out_pvld;
  logic        grad_out_prdy;
  logic [31:0] grad_out_pd;
  logic [4:0]  mask_cnt;
  logic [31:0] zero_cnt;

  nv_nvdla_sdp_hls_relu_bwd #(.DATA_WIDTH(32), .MASK_AW(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .op_en           (op_en),
    .mask_flush      (mask_flush),
    .fwd_pvld        (fwd_pvld),
    .fwd_prdy        (fwd_prdy),
    .fwd_pd          (fwd_pd),
    .grad_in_pvld    (grad_in_pvld),
    .grad_in_prdy    (grad_in_prdy),
    .grad_in_pd      (grad_in_pd),
    .grad_out_pvld   (grad_out_pvld),
    .grad_out_prdy   (grad_out_prdy),
    .grad_out_pd     (grad_out_pd),
    .mask_cnt        (mask_cnt),
    .zero_cnt        (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending derivative bits, output register contents, zero count.
  bit          mq[$];
  bit          m_out_v;
  logic [31:0] m_out_pd;
  logic [31:0] m_zcnt;
  logic [31:0] obs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out_v  = 1'b0;
    m_out_pd = '0;
    m_zcnt   = '0;
  endtask

  // Evaluated at the falling edge: checks DUT against model, then advances the model.
  task automatic eval_cycle();
    bit e_fp, e_gp, do_push, do_pop, h;
    e_fp = op_en && !mask_flush && (mq.size() != 16);
    e_gp = op_en && !mask_flush && (mq.size() != 0) && (!m_out_v || grad_out_prdy);
    chk("fwd_prdy", 64'(fwd_prdy), 64'(e_fp));
    chk("grad_in_prdy", 64'(grad_in_prdy), 64'(e_gp));
    chk("grad_out_pvld", 64'(grad_out_pvld), 64'(m_out_v));
    if (m_out_v) chk("grad_out_pd", 64'(grad_out_pd), 64'(m_out_pd));
    chk("mask_cnt", 64'(mask_cnt), 64'(mq.size()));
    chk("zero_cnt", 64'(zero_cnt), 64'(m_zcnt));
    if (grad_out_pvld && grad_out_prdy) obs.push_back(grad_out_pd);

    do_push = fwd_pvld && e_fp;
    do_pop  = grad_in_pvld && e_gp;
    if (mask_flush) begin
      mq.delete();
      m_zcnt = '0;
    end
    if (do_pop) begin
      h        = mq.pop_front();
      m_out_v  = 1'b1;
      m_out_pd = h ? grad_in_pd : 32'd0;
      if (!h && m_zcnt != 32'hFFFF_FFFF) m_zcnt++;
    end else if (m_out_v && grad_out_prdy) begin
      m_out_v = 1'b0;
    end
    if (do_push) mq.push_back($signed(fwd_pd) > 32'sd0);
  endtask

  task automatic step(input bit en, input bit fl, input bit fv, input logic [31:0] fd,
                      input bit gv, input logic [31:0] gd, input bit orr);
    op_en         = en;
    mask_flush    = fl;
    fwd_pvld      = fv;
    fwd_pd        = fd;
    grad_in_pvld  = gv;
    grad_in_pd    = gd;
    grad_out_prdy = orr;
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_x();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    int n;
    rst_n = 1'b0; op_en = 1'b1; mask_flush = 1'b0; fwd_pvld = 1'b0; fwd_pd = '0;
    grad_in_pvld = 1'b0; grad_in_pd = '0; grad_out_prdy = 1'b1;
    model_reset();
    #2;
    chk("rst_pvld", 64'(grad_out_pvld), 64'd0);
    chk("rst_pd", 64'(grad_out_pd), 64'd0);
    chk("rst_fwd_prdy", 64'(fwd_prdy), 64'd1);
    chk("rst_grad_in_prdy", 64'(grad_in_prdy), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic gating: {5,-3,0,max} -> {10,0,0,40}
    step(1, 0, 1, 32'd5, 0, 0, 1);
    step(1, 0, 1, 32'hFFFF_FFFD, 0, 0, 1);
    step(1, 0, 1, 32'd0, 0, 0, 1);
    step(1, 0, 1, 32'h7FFF_FFFF, 0, 0, 1);
    obs.delete();
    step(1, 0, 0, 0, 1, 32'd10, 1);
    step(1, 0, 0, 0, 1, 32'd20, 1);
    step(1, 0, 0, 0, 1, 32'd30, 1);
    step(1, 0, 0, 0, 1, 32'd40, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("basic_cnt", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) begin
      chk("basic_dx0", 64'(obs[0]), 64'd10);
      chk("basic_dx1", 64'(obs[1]), 64'd0);
      chk("basic_dx2", 64'(obs[2]), 64'd0);
      chk("basic_dx3", 64'(obs[3]), 64'd40);
    end
    chk("basic_zero_cnt", 64'(zero_cnt), 64'd2);

    // Fill to full, then pop one
    for (int i = 0; i < 17; i++) step(1, 0, 1, rand_x(), 0, 0, 1);
    chk("full_mask_cnt", 64'(mask_cnt), 64'd16);
    chk("full_fwd_prdy", 64'(fwd_prdy), 64'd0);
    step(1, 0, 1, rand_x(), 1, $urandom, 1);
    chk("after_pop_fwd_prdy", 64'(fwd_prdy), 64'd1);
    for (int i = 0; i < 40; i++) step(1, 0, 1, rand_x(), 1, $urandom, 1);

    // Drain to empty, then simultaneous push and gradient on empty FIFO
    n = 0;
    while (mask_cnt != 0 && n < 40) begin
      step(1, 0, 0, 0, 1, $urandom, 1);
      n++;
    end
    chk("drain_empty", 64'(mask_cnt), 64'd0);
    step(1, 0, 1, 32'd9, 1, 32'd77, 1);
    chk("no_bypass_pvld", 64'(grad_out_pvld), 64'd0);
    step(1, 0, 0, 0, 1, 32'd77, 1);
    chk("pop_next_pvld", 64'(grad_out_pvld), 64'd1);
    chk("pop_next_pd", 64'(grad_out_pd), 64'd77);
    step(1, 0, 0, 0, 0, 0, 1);

    // Backpressure for 5 cycles
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'd1 + i, 0, 0, 1);
    step(1, 0, 0, 0, 1, 32'h1234, 0);
    held = grad_out_pd;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, $urandom, 0);
    chk("bp_pd_stable", 64'(grad_out_pd), 64'(held));
    chk("bp_mask_kept", 64'(mask_cnt), 64'd3);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 32'h100 + i, 1);

    // Flush with 7 masks and an output pending
    for (int i = 0; i < 8; i++) step(1, 0, 1, rand_x(), 0, 0, 1);
    step(1, 0, 0, 0, 1, 32'h55, 0);
    chk("pre_flush_cnt", 64'(mask_cnt), 64'd7);
    step(1, 1, 1, 32'd3, 1, 32'h66, 0);
    chk("flush_cnt", 64'(mask_cnt), 64'd0);
    chk("flush_zero", 64'(zero_cnt), 64'd0);
    chk("flush_out_kept", 64'(grad_out_pvld), 64'd1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("flush_drained", 64'(grad_out_pvld), 64'd0);

    // Random traffic with backpressure, op_en toggling and rare flushes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 2) != 0, rand_x(),
           $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 9) < 7);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pvld", 64'(grad_out_pvld), 64'd0);
        chk("arst_pd", 64'(grad_out_pd), 64'd0);
        chk("arst_mask_cnt", 64'(mask_cnt), 64'd0);
        chk("arst_zero_cnt", 64'(zero_cnt), 64'd0);
        chk("arst_grad_in_prdy", 64'(grad_in_prdy), 64'd0);
        model_reset();
        fwd_pvld = 1'b0;
        grad_in_pvld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    n = 0;
    while ((mask_cnt != 0 || grad_out_pvld) && n < 100) begin
      step(1, 0, 0, 0, 1, $urandom, 1);
      n++;
    end
    chk("final_empty", 64'(mask_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
